// File: rtl/shift_deser_reg.sv
// shift_deser_reg: serial-in, parallel-out deserializer.
//
// Collects serial bits in either shift direction into an N-bit word and
// presents the word on a valid/ready parallel handshake.
//
// Optional build macro: SHIFT_DESER_PARITY_EN
//   When defined, each frame is N data bits followed by one even-parity bit.
//   The parity bit is checked but not stored, and the par_err output is added.
//
// Ports:
//   clk      in   clock, all state changes on posedge
//   clr      in   asynchronous active-high reset
//   s_bit    in   serial data bit
//   s_valid  in   s_bit valid this cycle
//   s_ready  out  a serial bit is accepted this cycle (low while FULL)
//   dir      in   0 = left shift (MSB first), 1 = right shift (LSB first)
//   abort    in   synchronous frame discard (ignored while FULL)
//   p_data   out  assembled word, held after the handshake
//   p_valid  out  p_data holds a complete word
//   p_ready  in   consumer accepts p_data
//   busy     out  a frame is in progress
//   bit_cnt  out  bits received in the current frame
//   par_err  out  parity mismatch, qualified by p_valid (parity build only)
module shift_deser_reg #(
    parameter int N  = 8,
`ifdef SHIFT_DESER_PARITY_EN
    parameter int CW = $clog2(N + 2)
`else
    parameter int CW = $clog2(N + 1)
`endif
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          s_bit,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          dir,
    input  logic          abort,
    output logic [N-1:0]  p_data,
    output logic          p_valid,
    input  logic          p_ready,
    output logic          busy,
`ifdef SHIFT_DESER_PARITY_EN
    output logic          par_err,
`endif
    output logic [CW-1:0] bit_cnt
);

`ifdef SHIFT_DESER_PARITY_EN
    localparam int FL = N + 1;
`else
    localparam int FL = N;
`endif
    localparam logic [CW-1:0] LAST = CW'(FL - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

    state_t       state, state_nx;
    logic [N-1:0] shreg;
    logic [N-1:0] shifted;
    logic         dir_q;
    logic         eff_dir;
    logic         xfer;
    logic         last;

    assign s_ready = (state != FULL);
    assign p_valid = (state == FULL);
    assign busy    = (state == SHIFT);

    always_comb begin
        // The first bit of a frame uses the live dir; later bits use the
        // direction latched with that first bit.
        eff_dir = (state == IDLE) ? dir : dir_q;
        shifted = eff_dir ? {s_bit, shreg[N-1:1]} : {shreg[N-2:0], s_bit};
        xfer    = s_valid && s_ready;
        last    = (bit_cnt == LAST);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (abort)     state_nx = IDLE;
                else if (xfer) state_nx = SHIFT;
            end
            SHIFT: begin
                if (abort)             state_nx = IDLE;
                else if (xfer && last) state_nx = FULL;
            end
            FULL: begin
                if (p_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef SHIFT_DESER_PARITY_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            shreg   <= '0;
            p_data  <= '0;
            bit_cnt <= '0;
            dir_q   <= 1'b0;
            par_err <= 1'b0;
        end else begin
            case (state)
                IDLE, SHIFT: begin
                    if (abort) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                        par_err <= 1'b0;
                    end else if (xfer) begin
                        bit_cnt <= bit_cnt + CW'(1);
                        if (state == IDLE) dir_q <= dir;
                        // The trailing parity bit is compared, never shifted in.
                        if (state == SHIFT && last) begin
                            p_data  <= shreg;
                            par_err <= s_bit ^ (^shreg);
                        end else begin
                            shreg <= shifted;
                        end
                    end
                end
                FULL: begin
                    if (p_ready) begin
                        bit_cnt <= '0;
                        par_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            shreg   <= '0;
            p_data  <= '0;
            bit_cnt <= '0;
            dir_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, SHIFT: begin
                    if (abort) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                    end else if (xfer) begin
                        bit_cnt <= bit_cnt + CW'(1);
                        shreg   <= shifted;
                        if (state == IDLE) dir_q <= dir;
                        if (state == SHIFT && last) p_data <= shifted;
                    end
                end
                FULL: begin
                    if (p_ready) bit_cnt <= '0;
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_shift_deser_reg.sv
// Self-checking bench for shift_deser_reg: directed frames plus random
// traffic, compared every cycle against a frame-level reference model.
module tb_shift_deser_reg;

    localparam int N = 8;
`ifdef SHIFT_DESER_PARITY_EN
    localparam int CW = $clog2(N + 2);
    localparam int FL = N + 1;
`else
    localparam int CW = $clog2(N + 1);
    localparam int FL = N;
`endif

    logic          clk = 1'b0;
    logic          clr;
    logic          s_bit, s_valid, dir, abort, p_ready;
    logic          s_ready, p_valid, busy;
    logic [N-1:0]  p_data;
    logic [CW-1:0] bit_cnt;
`ifdef SHIFT_DESER_PARITY_EN
    logic          par_err;
`endif

    shift_deser_reg #(.N(N)) dut (
        .clk     (clk),
        .clr     (clr),
        .s_bit   (s_bit),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .dir     (dir),
        .abort   (abort),
        .p_data  (p_data),
        .p_valid (p_valid),
        .p_ready (p_ready),
        .busy    (busy),
`ifdef SHIFT_DESER_PARITY_EN
        .par_err (par_err),
`endif
        .bit_cnt (bit_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: bits of the current frame in arrival order.
    bit           q[$];
    bit           m_full;
    bit           m_fdir;
    bit           m_perr;
    logic [N-1:0] m_pdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] assemble();
        logic [N-1:0] w;
        w = '0;
        // Left shift: first bit lands in the MSB. Right shift: first bit in the LSB.
        for (int i = 0; i < N; i++)
            if (q[i]) w[m_fdir ? i : N - 1 - i] = 1'b1;
        return w;
    endfunction

    task automatic model_reset();
        q.delete();
        m_full  = 1'b0;
        m_fdir  = 1'b0;
        m_perr  = 1'b0;
        m_pdata = '0;
    endtask

    task automatic compare_all();
        check_eq("p_valid", 32'(p_valid), 32'(m_full));
        check_eq("s_ready", 32'(s_ready), 32'(!m_full));
        check_eq("busy",    32'(busy),    32'(!m_full && q.size() > 0));
        check_eq("bit_cnt", 32'(bit_cnt), m_full ? 32'(FL) : 32'(q.size()));
        check_eq("p_data",  32'(p_data),  32'(m_pdata));
`ifdef SHIFT_DESER_PARITY_EN
        check_eq("par_err", 32'(par_err), 32'(m_full && m_perr));
`endif
    endtask

    // Inputs are already applied; advance one edge, update model, compare.
    task automatic step();
        bit x;
        @(posedge clk);
        #1;
        if (m_full) begin
            if (p_ready) begin
                m_full = 1'b0;
                m_perr = 1'b0;
            end
        end else if (abort) begin
            q.delete();
        end else if (s_valid) begin
            if (q.size() == 0) m_fdir = dir;
            q.push_back(s_bit);
            if (q.size() == FL) begin
                m_pdata = assemble();
                x = 1'b0;
                for (int i = 0; i < N; i++) x = x ^ q[i];
                m_perr = (FL > N) ? (q[FL-1] != x) : 1'b0;
                m_full = 1'b1;
                q.delete();
            end
        end
        compare_all();
    endtask

    // Send a word in frame order for direction d; dir flips after bit toggle_at.
    task automatic send_word(input logic [N-1:0] w, input bit d, input int toggle_at, input bit par);
        for (int i = 0; i < N; i++) begin
            s_valid = 1'b1;
            s_bit   = w[d ? i : N - 1 - i];
            dir     = (toggle_at >= 0 && i > toggle_at) ? ~d : d;
            step();
        end
`ifdef SHIFT_DESER_PARITY_EN
        s_bit = par;
        step();
`else
        if (par) s_bit = 1'b0;
`endif
        s_valid = 1'b0;
    endtask

    task automatic async_clear();
        #3 clr = 1'b1;
        #1;
        model_reset();
        check_eq("clr_pvalid", 32'(p_valid), 32'd0);
        check_eq("clr_busy",   32'(busy),    32'd0);
        check_eq("clr_cnt",    32'(bit_cnt), 32'd0);
        check_eq("clr_sready", 32'(s_ready), 32'd1);
        check_eq("clr_pdata",  32'(p_data),  32'd0);
        #2 clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1; s_bit = 1'b0; s_valid = 1'b0; dir = 1'b0; abort = 1'b0; p_ready = 1'b1;
        model_reset();
        #1;
        check_eq("rst_pvalid", 32'(p_valid), 32'd0);
        check_eq("rst_sready", 32'(s_ready), 32'd1);
        check_eq("rst_busy",   32'(busy),    32'd0);
        check_eq("rst_cnt",    32'(bit_cnt), 32'd0);
        check_eq("rst_pdata",  32'(p_data),  32'd0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;

        // Left shift, back-to-back, consumer ready.
        send_word(8'hB2, 1'b0, -1, 1'b0);
        check_eq("t1_valid", 32'(p_valid), 32'd1);
        check_eq("t1_word",  32'(p_data),  32'hB2);
        step();
        check_eq("t1_idle",  32'(p_valid), 32'd0);

        // Right shift, same bit sequence; then with dir toggled mid-frame.
        send_word(8'h4D, 1'b1, -1, 1'b0);
        check_eq("t2_word", 32'(p_data), 32'h4D);
        step();
        send_word(8'h4D, 1'b1, 2, 1'b0);
        check_eq("t2_toggle", 32'(p_data), 32'h4D);
        step();

        // Back-pressure with s_valid held high.
        p_ready = 1'b0;
        send_word(8'h5A, 1'b0, -1, 1'b0);
        s_valid = 1'b1; s_bit = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check_eq("t3_word", 32'(p_data), 32'h5A);
        p_ready = 1'b1;
        step();
        check_eq("t3_hs", 32'(p_valid), 32'd0);
        step();
        check_eq("t3_next", 32'(bit_cnt), 32'd1);
        s_valid = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;

        // Abort after 4 bits, then a clean 8'hFF frame.
        s_valid = 1'b1; s_bit = 1'b0; dir = 1'b0;
        for (int i = 0; i < 4; i++) step();
        s_valid = 1'b1; abort = 1'b1;
        step();
        abort = 1'b0; s_valid = 1'b0;
        check_eq("t4_busy", 32'(busy),    32'd0);
        check_eq("t4_cnt",  32'(bit_cnt), 32'd0);
        send_word(8'hFF, 1'b0, -1, 1'b0);
        check_eq("t4_word", 32'(p_data), 32'hFF);
        step();

        // Asynchronous clear mid-frame and while FULL.
        s_valid = 1'b1; s_bit = 1'b1;
        for (int i = 0; i < 3; i++) step();
        s_valid = 1'b0;
        async_clear();
        step();
        p_ready = 1'b0;
        send_word(8'hC3, 1'b1, -1, 1'b0);
        async_clear();
        p_ready = 1'b1;
        step();
        check_eq("t5_novalid", 32'(p_valid), 32'd0);

`ifdef SHIFT_DESER_PARITY_EN
        send_word(8'hB2, 1'b0, -1, 1'b0);
        check_eq("t6_ok", 32'(par_err), 32'd0);
        step();
        p_ready = 1'b0;
        send_word(8'hB2, 1'b0, -1, 1'b1);
        check_eq("t6_err",   32'(par_err), 32'd1);
        check_eq("t6_valid", 32'(p_valid), 32'd1);
        p_ready = 1'b1;
        step();
        check_eq("t6_clear", 32'(par_err), 32'd0);
`endif

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_bit   = $urandom_range(0, 1);
            dir     = $urandom_range(0, 1);
            abort   = ($urandom_range(0, 15) == 0);
            p_ready = $urandom_range(0, 1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_deser_reg.md
Name: shift_deser_reg

Overview:
- Serial-in, parallel-out deserializer; the receiving end of the team's load/shift register datapath.
- Collects N serial bits in either shift direction into a word and presents it on a valid/ready parallel handshake.
- Sits between a serial bit source (shift-register transmitter or external link) and the parallel accumulator/register file.

Parameters:
N, 8, word width in bits (N >= 2).
CW, $clog2(N+1), bit-counter width (derived; not overridden).

Ports:
clk  input  1  clock; all state changes on posedge.
clr  input  1  asynchronous, active-high reset.
s_bit  input  1  serial data bit.
s_valid  input  1  s_bit is valid this cycle.
s_ready  output  1  block accepts a serial bit this cycle.
dir  input  1  0 = left shift (MSB first; new bit enters bit 0), 1 = right shift (LSB first; new bit enters bit N-1).
abort  input  1  synchronous frame discard.
p_data  output  N  assembled word.
p_valid  output  1  p_data holds a complete word.
p_ready  input  1  consumer accepts p_data.
busy  output  1  a frame is in progress (state SHIFT).
bit_cnt  output  CW  bits received in the current frame.

Behaviour:
- Reset: clr high -> state IDLE; p_data = 0, p_valid = 0, busy = 0, bit_cnt = 0, s_ready = 1. Takes effect immediately, mid-frame included; the partial word is lost.
- Serial transfer occurs on a cycle with s_valid and s_ready both high.
- s_ready = 1 in IDLE and SHIFT; 0 in FULL.
- Frame direction: dir is sampled on the first transfer of a frame and held internally until the frame ends. Changes to dir mid-frame are ignored.
- Shift on each transfer:
  - Left: shreg <= {shreg[N-2:0], s_bit}.
  - Right: shreg <= {s_bit, shreg[N-1:1]}.
- State machine:
  - IDLE: transfer -> shift, bit_cnt = 1, go to SHIFT.
  - SHIFT: transfer -> shift, bit_cnt + 1. When the Nth bit is accepted, go to FULL and load p_data from the shift result in the same edge. No transfer -> hold; gaps of any length are allowed.
  - FULL: p_valid = 1; p_data stable until handshake. p_ready high -> next cycle IDLE, p_valid = 0, bit_cnt = 0.
- Latency: p_valid rises on the clock edge that accepts bit N, so it is visible the cycle after that transfer.
- FULL with p_ready low: back-pressure; s_ready = 0 and s_bit is ignored.
- p_data keeps its last value after the handshake; only p_valid qualifies it.
- abort, in IDLE or SHIFT: next state IDLE, bit_cnt = 0, shift register cleared. abort has priority over a simultaneous transfer.
- abort in FULL: ignored; a completed word is never discarded.
- Priority: clr > abort > transfer/handshake.
- busy = (state == SHIFT).
- bit_cnt is valid 0..N and never wraps.
- N = 2 is the smallest legal configuration.

Optional Feature:
- Macro: SHIFT_DESER_PARITY_EN.
- When defined:
  - Each frame carries N+1 bits; the (N+1)th bit is even parity over the N data bits.
  - The block enters FULL after the parity bit, not after the Nth data bit.
  - Adds output port par_err (1 bit): set with p_valid when the received parity does not match; cleared by the p handshake, by abort and by clr.
  - The parity bit is not shifted into p_data. bit_cnt counts to N+1.
- When undefined: no par_err port, N-bit frames, behaviour exactly as above.

Test Plan:
1. Reset, then dir=0, send 1,0,1,1,0,0,1,0 back-to-back with p_ready=1 -> p_valid one cycle after the 8th bit, p_data = 8'hB2, IDLE on the next cycle.
2. dir=1, same bit sequence -> p_data = 8'h4D. Toggle dir after bit 3 -> result unchanged.
3. Complete word with p_ready=0 for 5 cycles while s_valid=1 -> s_ready=0 throughout, p_data stable. Raise p_ready -> handshake, and the next frame's first bit is accepted on the following cycle.
4. abort after 4 bits -> busy=0, bit_cnt=0. Then a full new frame of 8'hFF -> p_data = 8'hFF with no stale bits.
5. clr pulsed asynchronously mid-frame (between edges) and again in FULL -> all outputs return to reset values immediately, with no p_valid pulse.
6. With SHIFT_DESER_PARITY_EN defined: data 8'hB2 with parity bit 0 -> par_err=0. With parity bit 1 -> par_err=1 together with p_valid, cleared after the handshake.
